// File: rtl/mem_stage_requester.sv
// mem_stage_requester: Y86-64 memory-stage initiator issuing valid/ready data-memory requests; optional response timeout via MEM_TIMEOUT_EN
module mem_stage_requester #(
    parameter int MEM_BYTES      = 8192,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_rdata,
    input  logic        mem_rsp_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [63:0] out_valM,
    output logic [2:0]  out_stat
);
    typedef enum logic [2:0] {IDLE, REQ, RSP, OUT, HALTED} state_t;
    localparam logic [2:0]  AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        req_valid_q, req_valid_d, req_we_q, req_we_d, out_valid_q, out_valid_d;
    logic [63:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d, out_valM_q, out_valM_d;
    logic [3:0]  out_icode_q, out_icode_d;
    logic [2:0]  out_stat_q, out_stat_d;
    logic        is_rd, is_wr, addr_err, go;
    logic [63:0] addr, wdata;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Decode the incoming instruction into a memory access and its static status
    always_comb begin
        is_rd    = icode == 4'd5 || icode == 4'd9 || icode == 4'd11;
        is_wr    = icode == 4'd4 || icode == 4'd8 || icode == 4'd10;
        addr     = (icode == 4'd9 || icode == 4'd11) ? valA : valE;
        wdata    = icode == 4'd8 ? valP : valA;
        addr_err = (is_rd || is_wr) && addr > MAX_ADDR;
        go       = (is_rd || is_wr) && !imem_error && instr_valid && !addr_err;
    end

    // Next-state and next-output computation for the request FSM
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        out_valM_d  = out_valM_q;
        out_stat_d  = out_stat_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                out_icode_d = icode;
                out_valM_d  = '0;
                req_we_d    = is_wr;
                req_addr_d  = addr;
                req_wdata_d = wdata;
                out_stat_d  = imem_error ? ADR : !instr_valid ? INS : addr_err ? ADR : icode == 4'd0 ? HLT : AOK;
                state_d     = go ? REQ : OUT;
                req_valid_d = go;
                out_valid_d = !go;
            end
            REQ: if (mem_req_ready) begin
                req_valid_d = 1'b0;
                state_d     = RSP;
`ifdef MEM_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            RSP: if (mem_rsp_valid) begin
                out_valM_d  = req_we_q ? 64'd0 : mem_rsp_rdata;
                out_stat_d  = mem_rsp_error ? ADR : out_stat_q;
                state_d     = OUT;
                out_valid_d = 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                out_valM_d  = '0;
                out_stat_d  = ADR;
                state_d     = OUT;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            OUT: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = out_stat_q == AOK ? IDLE : HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    // State and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_icode_q <= '0;
            out_valM_q  <= '0;
            out_stat_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            out_valM_q  <= out_valM_d;
            out_stat_q  <= out_stat_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready      = state_q == IDLE;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign out_valid     = out_valid_q;
    assign out_icode     = out_icode_q;
    assign out_valM      = out_valM_q;
    assign out_stat      = out_stat_q;
endmodule

// File: tb/tb_mem_stage_requester.sv
// tb_mem_stage_requester: directed table-driven bench for mem_stage_requester
module tb_mem_stage_requester;
`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 64;
`endif
    logic        clk = 1'b0, rst, in_valid, in_ready, instr_valid, imem_error;
    logic [3:0]  icode, out_icode;
    logic [63:0] valE, valA, valP, mem_req_addr, mem_req_wdata, mem_rsp_rdata, out_valM;
    logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, mem_rsp_error, out_valid, out_ready;
    logic [2:0]  out_stat;
    int          n_cmp = 0, n_bad = 0;

    mem_stage_requester #(.MEM_BYTES(8192), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_error(mem_rsp_error), .out_valid(out_valid),
        .out_ready(out_ready), .out_icode(out_icode), .out_valM(out_valM), .out_stat(out_stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE, valA, valP;
        logic        iv, ie;
        logic [63:0] rdata;
        logic        rerr, req, we;
        logic [63:0] addr, wdata;
        logic [2:0]  stat;
        logic [63:0] valM;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_error = 1'b0;
        icode = '0; valE = '0; valA = '0; valP = '0; instr_valid = 1'b0; imem_error = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst out_stat", 64'(out_stat), 64'd0);
    endtask

    task automatic accept(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                          input logic [63:0] p, input logic iv, input logic ie);
        icode = ic; valE = e; valA = a; valP = p; instr_valid = iv; imem_error = ie; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int  lat = 0, reqs = 0;
        logic prev_hs = 1'b0;
        do_reset;
        mem_req_ready = 1'b1;
        accept(v.icode, v.valE, v.valA, v.valP, v.iv, v.ie);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            mem_rsp_valid = prev_hs;
            mem_rsp_rdata = prev_hs ? v.rdata : 64'd0;
            mem_rsp_error = prev_hs & v.rerr;
            prev_hs = mem_req_valid & mem_req_ready;
            if (mem_req_valid) begin
                reqs++;
                chk($sformatf("v%0d addr", id), mem_req_addr, v.addr);
                chk($sformatf("v%0d we", id), 64'(mem_req_we), 64'(v.we));
                if (v.we) chk($sformatf("v%0d wdata", id), mem_req_wdata, v.wdata);
            end
            if (out_valid) lat = k;
        end
        mem_rsp_valid = 1'b0;
        chk($sformatf("v%0d latency", id), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d reqs", id), 64'(reqs), 64'(v.req ? 1 : 0));
        chk($sformatf("v%0d stat", id), 64'(out_stat), 64'(v.stat));
        chk($sformatf("v%0d valM", id), out_valM, v.valM);
        chk($sformatf("v%0d icode", id), 64'(out_icode), 64'(v.icode));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d out_valid drop", id), 64'(out_valid), 64'd0);
        chk($sformatf("v%0d in_ready after", id), 64'(in_ready), 64'(v.stat == 3'd1));
        if (v.stat != 3'd1) begin
            icode = 4'd5; valE = 64'h100; instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d halted req", id), 64'(mem_req_valid), 64'd0);
            chk($sformatf("v%0d halted out", id), 64'(out_valid), 64'd0);
            chk($sformatf("v%0d halted ready", id), 64'(in_ready), 64'd0);
            in_valid = 1'b0;
        end
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{4'd5,  64'h100, 64'h0, 64'h0, 1'b1, 1'b0, 64'hDEADBEEF, 1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 3'd1, 64'hDEADBEEF, 3};
        vt[1]  = '{4'd8,  64'h1F8, 64'h999, 64'h40, 1'b1, 1'b0, 64'h1234, 1'b0, 1'b1, 1'b1, 64'h1F8, 64'h40, 3'd1, 64'h0, 3};
        vt[2]  = '{4'd11, 64'h0, 64'h2000, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd3, 64'h0, 1};
        vt[3]  = '{4'd0,  64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd2, 64'h0, 1};
        vt[4]  = '{4'd6,  64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd4, 64'h0, 1};
        vt[5]  = '{4'd6,  64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd3, 64'h0, 1};
        vt[6]  = '{4'd9,  64'h0, 64'h1FF8, 64'h0, 1'b1, 1'b0, 64'h55, 1'b0, 1'b1, 1'b0, 64'h1FF8, 64'h0, 3'd1, 64'h55, 3};
        vt[7]  = '{4'd4,  64'h1FF9, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd3, 64'h0, 1};
        vt[8]  = '{4'd5,  64'h10, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 3'd3, 64'h0, 3};
        vt[9]  = '{4'd6,  64'h1FFF, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd1, 64'h0, 1};
        vt[10] = '{4'd5,  64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd3, 64'h0, 1};
        vt[11] = '{4'd0,  64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 3'd3, 64'h0, 1};
        for (int i = 0; i < 12; i++) run_vec(vt[i], i);

        // pushq with mem_req_ready held low for 5 cycles
        do_reset;
        accept(4'd10, 64'h80, 64'h7, 64'h0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall valid", 64'(mem_req_valid), 64'd1);
            chk("stall addr", mem_req_addr, 64'h80);
            chk("stall wdata", mem_req_wdata, 64'h7);
            chk("stall we", 64'(mem_req_we), 64'd1);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("stall single hs", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hABCD;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stall out_valid", 64'(out_valid), 64'd1);
        chk("stall stat", 64'(out_stat), 64'd1);
        chk("stall valM", out_valM, 64'd0);
        chk("stall no 2nd req", 64'(mem_req_valid), 64'd0);

        // reset while waiting in RSP, then a stray late response
        do_reset;
        mem_req_ready = 1'b1;
        accept(4'd5, 64'h100, 64'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rsp-rst req", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsp-rst in_ready", 64'(in_ready), 64'd1);
        chk("rsp-rst out_valid", 64'(out_valid), 64'd0);
        chk("rsp-rst req_valid", 64'(mem_req_valid), 64'd0);
        chk("rsp-rst addr", mem_req_addr, 64'd0);
        chk("rsp-rst icode", 64'(out_icode), 64'd0);
        chk("rsp-rst stat", 64'(out_stat), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h77;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("late rsp out_valid", 64'(out_valid), 64'd0);
        chk("late rsp in_ready", 64'(in_ready), 64'd1);
        chk("late rsp valM", out_valM, 64'd0);

`ifdef MEM_TIMEOUT_EN
        // no response: ADR after TO cycles in RSP
        begin
            int lat = 0;
            do_reset;
            mem_req_ready = 1'b1;
            accept(4'd5, 64'h100, 64'h0, 64'h0, 1'b1, 1'b0);
            for (int k = 1; k <= 20 && lat == 0; k++) begin
                @(negedge clk);
                if (out_valid) lat = k;
            end
            chk("timeout latency", 64'(lat), 64'(TO + 2));
            chk("timeout stat", 64'(out_stat), 64'd3);
            chk("timeout valM", out_valM, 64'd0);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_requester.md
Name: mem_stage_requester

Overview:
- Memory-access initiator for the Y86-64 processor.
- Takes one decoded/executed instruction at a time, computes the data-memory address and write data, and issues a request over a valid/ready request/response interface to the data memory.
- Returns valM and the final status code to write-back.
- Sits between execute and write-back; the data memory array is the responder on the other end of this interface.

Parameters:
- MEM_BYTES, 8192: size of the byte-addressed data memory. A legal 8-byte access requires addr <= MEM_BYTES-8.
- TIMEOUT_CYCLES, 64: response wait limit. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction from execute is valid
- in_ready  out  1  block can accept an instruction
- icode  in  4  instruction code
- valE  in  64  ALU result
- valA  in  64  register A value
- valP  in  64  next PC
- instr_valid  in  1  fetch flagged the instruction legal
- imem_error  in  1  fetch flagged an instruction-memory error
- mem_req_valid  out  1  request to data memory
- mem_req_ready  in  1  data memory accepts the request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  64  byte address
- mem_req_wdata  out  64  store data
- mem_rsp_valid  in  1  response valid
- mem_rsp_rdata  in  64  load data
- mem_rsp_error  in  1  data memory reported an error
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts the result
- out_icode  out  4  registered icode
- out_valM  out  64  load result; 0 for non-loads
- out_stat  out  3  AOK=1, HLT=2, ADR=3, INS=4

Behaviour:
- Reset: synchronous on rst high, highest priority, any state, including mid-request.
  - All outputs clear to 0: mem_req_valid, out_valid, out_valM, out_icode, out_stat, mem_req_*.
  - FSM goes to IDLE.
  - A mem_rsp_valid arriving outside RSP is ignored.
- FSM states: IDLE, REQ, RSP, OUT, HALTED.
- IDLE:
  - in_ready=1.
  - On in_valid, latch icode/valE/valA/valP/instr_valid/imem_error.
  - Then go to REQ if the instruction is a memory op with no fetch error and no local address error; otherwise go to OUT.
- Memory op decode:
  - Reads: mrmovq(5), popq(11), ret(9).
  - Writes: rmmovq(4), pushq(10), call(8).
  - Address: valE for 4, 5, 8, 10; valA for 9, 11.
  - Write data: valP for call(8); valA for 4 and 10.
- Local address error: address > MEM_BYTES-8. Compare in 64 bits with no overflow. On error, no request is issued and the result is ADR.
- REQ:
  - mem_req_valid=1 with addr/we/wdata held stable until mem_req_ready.
  - On the handshake cycle, go to RSP.
- RSP:
  - Wait for mem_rsp_valid.
  - On a read, capture rdata into out_valM.
  - mem_rsp_error=1 yields ADR.
  - Then go to OUT.
  - A write also waits for its response (acknowledge); its rdata is ignored.
- OUT:
  - out_valid=1; outputs held stable until out_ready.
  - On handshake:
    - if out_stat==AOK, go to IDLE;
    - else go to HALTED.
- HALTED:
  - in_ready=0, no requests issued.
  - Remains until rst.
- Status priority, highest first: imem_error→ADR; !instr_valid→INS; memory address/response error→ADR; icode==0→HLT; otherwise AOK.
- Latency:
  - Non-memory instruction: accepted at cycle N → out_valid at N+1.
  - Memory op with mem_req_ready=1 and the response one cycle after the request handshake:
    - request at N+1;
    - response at N+2;
    - out_valid at N+3.
- Exactly one outstanding request at any time; in_ready=0 in every state except IDLE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in RSP.
  - If TIMEOUT_CYCLES cycles elapse without mem_rsp_valid, go to OUT with out_stat=ADR and out_valM=0.
  - A response arriving afterward is ignored.
  - The counter clears on entry to RSP.
- MEM_TIMEOUT_EN undefined: RSP waits indefinitely; no counter logic.

Test Plan:
- mrmovq: icode=5, valE=0x100, memory returns 0xDEADBEEF → one read request at addr 0x100, out_valM=0xDEADBEEF, out_stat=1, out_valid 3 cycles after accept.
- call: icode=8, valE=0x1F8, valP=0x40 → write request with addr=0x1F8, wdata=0x40, we=1; out_stat=1; out_valM=0.
- popq: icode=11, valA=0x2000 with MEM_BYTES=8192 → no mem_req_valid pulse, out_stat=3, then HALTED with in_ready=0 until rst.
- mem_req_ready held low 5 cycles during pushq: icode=10, valE=0x80, valA=0x7 → addr/wdata/we stable all 5 cycles; single handshake; result AOK.
- halt (icode=0, instr_valid=1) → out_stat=2 after 1 cycle, then HALTED. instr_valid=0 → out_stat=4. imem_error=1 together with instr_valid=0 → out_stat=3.
- rst asserted during RSP → next cycle IDLE, in_ready=1, all outputs 0; a late mem_rsp_valid produces no out_valid. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no response → out_stat=3 after 4 RSP cycles.
